// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-wide data memory.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_access_unit #(
  parameter int unsigned DM_AW = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_din,
  output logic [3:0]       dm_loadsel,
  output logic [1:0]       dm_byte,
  input  logic [31:0]      dm_dout
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [DM_AW+1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic        req_mis, req_oor, req_err;
  logic [31:0] merged, extended;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    unique case (req_size)
      2'b00:   req_mis = 1'b0;
      2'b01:   req_mis = req_addr[0];
      2'b10:   req_mis = (req_addr[1:0] != 2'b00);
      default: req_mis = 1'b1;
    endcase
    req_oor = |(req_addr >> (DM_AW + 2));
    req_err = req_mis | req_oor;
  end

  // Store merge works on the word sampled in StRd; word stores bypass it.
  always_comb begin
    merged = word_q;
    unique case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    rd_byte = dm_dout[{addr_q[1:0], 3'b000} +: 8];
    rd_half = dm_dout[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   extended = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   extended = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: extended = dm_dout;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[DM_AW+1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            state_d = StResp;
            rdata_d = 32'b0;
            err_d   = 1'b1;
          end else if (req_we && req_size == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        word_d = dm_dout;
        if (we_q) begin
          state_d = StWr;
        end else begin
          state_d = StResp;
          rdata_d = extended;
          err_d   = 1'b0;
        end
      end
      StWr: begin
        state_d = StResp;
        rdata_d = 32'b0;
        err_d   = 1'b0;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'b0;
      word_q  <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Pure state decodes, so an async reset drops them immediately.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign dm_we      = (state_q == StWr);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dm_addr    = addr_q[DM_AW+1:2];
  assign dm_byte    = addr_q[1:0];
  assign dm_din     = merged;
  assign dm_loadsel = 4'b0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses against a behavioural word memory.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, dm_we;
  logic [31:0] resp_rdata, dm_din, dm_dout;
  logic [6:0]  dm_addr;
  logic [3:0]  dm_loadsel;
  logic [1:0]  dm_byte;

  mem_access_unit #(.DM_AW(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din),
    .dm_loadsel(dm_loadsel), .dm_byte(dm_byte), .dm_dout(dm_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data memory with a bench-side preload port.
  logic [31:0] mem [128];
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [31:0] pre_data;
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;
  typedef struct {
    logic [6:0]  a;
    logic [31:0] d;
  } wexp_t;

  exp_t  sbq[$];
  wexp_t wq[$];
  int    cmp = 0;
  int    bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: resp_valid captured at edge cyc+1, so latency = cyc - acc + 1.
  exp_t  me;
  wexp_t mw;
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected no response",
                 resp_rdata, resp_err);
      end else begin
        me = sbq.pop_front();
        chk("resp_rdata", resp_rdata, me.rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, me.err});
        chk("latency", cyc - me.acc + 1, me.lat);
        chk("ready_in_resp", {31'b0, req_ready}, 32'd0);
      end
    end
    if (dm_we) begin
      if (wq.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL unexpected_write: got addr %h din %h expected no write", dm_addr, dm_din);
      end else begin
        mw = wq.pop_front();
        chk("dm_addr", {25'b0, dm_addr}, {25'b0, mw.a});
        chk("dm_din", dm_din, mw.d);
      end
    end
  end

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Present a request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat, input bit push);
    int   n;
    exp_t e;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      cmp++;
      bad++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1 within 20 cycles");
      return;
    end
    e.rdata = er; e.err = ee; e.acc = cyc + 1; e.lat = lat;
    if (push) sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_accept", {31'b0, req_ready}, 32'd0);
  endtask

  // Drop the request and scramble req_* to show the in-flight access ignores them.
  task automatic idle_wait();
    int n;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while ((sbq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0 || wq.size() != 0) begin
      cmp++;
      bad++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sbq.size() + wq.size());
      sbq.delete();
      wq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h12345678; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_dm_we", {31'b0, dm_we}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Word store then word load.
    wq.push_back('{a: 7'd4, d: 32'hDEADBEEF});
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
    idle_wait();

    // Byte store RMW, then read back.
    preload(7'd8, 32'h11223344);
    wq.push_back('{a: 7'd8, d: 32'h11AA3344});
    issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1);
    idle_wait();
    issue(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, 32'h11AA3344, 1'b0, 2, 1'b1);
    idle_wait();

    // Load extension on 0x80FF7F01.
    preload(7'd12, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 32'h00000080, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'h00007F01, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h000080FF, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'h0000007F, 1'b0, 2, 1'b1);
    idle_wait();

    // Upper-halfword store merge.
    preload(7'd13, 32'hA5A5A5A5);
    wq.push_back('{a: 7'd13, d: 32'hBEEFA5A5});
    issue(1'b1, 2'b01, 1'b0, 32'h36, 32'h1234BEEF, 32'h0, 1'b0, 3, 1'b1);
    idle_wait();

    // Errors: one-cycle latency, no write; a load first leaves resp_rdata nonzero.
    issue(1'b0, 2'b10, 1'b0, 32'h34, 32'h0, 32'hBEEFA5A5, 1'b0, 2, 1'b1);
    idle_wait();
    issue(1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF, 32'h0, 1'b1, 1, 1'b1);
    idle_wait();
    issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    idle_wait();
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    idle_wait();
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    idle_wait();
    issue(1'b1, 2'b00, 1'b0, 32'h201, 32'h77, 32'h0, 1'b1, 1, 1'b1);
    idle_wait();

    // Reset during WR of a byte store: accept edge A, RD after A, WR after A+1.
    preload(7'd9, 32'h55667788);
    issue(1'b1, 2'b00, 1'b0, 32'h25, 32'h000000CC, 32'h0, 1'b0, 3, 1'b0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 chk("abort_in_wr", {31'b0, dm_we}, 32'd1);
    rst = 1'b1;
    #1 chk("abort_we_drop", {31'b0, dm_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_mem", mem[9], 32'h55667788);
    issue(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h55667788, 1'b0, 2, 1'b1);
    idle_wait();

    // Three requests with req_valid held high: each accepted once, in order.
    wq.push_back('{a: 7'd20, d: 32'hCAFEF00D});
    issue(1'b1, 2'b10, 1'b0, 32'h50, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
    issue(1'b0, 2'b00, 1'b1, 32'h51, 32'h0, 32'h000000F0, 1'b0, 2, 1'b1);
    idle_wait();
    repeat (3) @(negedge clk);

    chk("sb_drained", sbq.size(), 32'd0);
    chk("wq_drained", wq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
